// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus pacer feeding a UART transmitter that has no ready output.
// Latency: a byte written into an empty, idle block is issued (tx_vld) two cycles after the write edge.
// Backpressure: none upstream; writes to a full FIFO are dropped and flagged with a one-cycle ovf pulse.
module uart_tx_feeder #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int BAUD_DIV   = 5208,
  parameter int FRAME_BITS = 10,
  parameter int GAP_CYC    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  busy,
  output logic                  tx_vld,
  output logic [DATA_W-1:0]     tx_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PACE  = FRAME_BITS * BAUD_DIV + GAP_CYC;
  localparam int CNT_W = $clog2(PACE);
  // WAIT lasts PACE-2 cycles; IDLE and ISSUE supply the other two, so back-to-back issues are PACE apart.
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PACE - 3);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     level_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    push;
  logic                    pop;

  // A write is taken only when the registered full flag says there is room.
  assign push = wr_en && !full;

  // Storage array; no reset needed since only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Occupancy after this edge, accounting for a simultaneous push and pop.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // FIFO pointers, level, full and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      ovf   <= wr_en && full;
    end
  end

  // Pacer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pacer next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (level != '0) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pacer outputs: the head is consumed during the single ISSUE cycle.
  always_comb begin
    pop = (state == ISSUE);
  end

  // Pace counter: held at zero outside WAIT so it starts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state != WAIT)  cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  // Registered issue strobe; tx_data changes only together with tx_vld and then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_vld  <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_vld <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

  assign busy = (level != '0) || (state != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised and directed bench for uart_tx_feeder with a timing-rule reference model and scoreboard.
// Small divider (PACE = 4*10+2 = 42) and a depth-4 FIFO keep runs short.
// A transmitter model flags any tx_vld that arrives while it is still sending a frame.
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  localparam int BDIV  = 4;
  localparam int FBITS = 10;
  localparam int GAP   = 2;
  localparam int FRAME = FBITS * BDIV;
  localparam int PACE  = FRAME + GAP;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [DW-1:0]  wr_data;
  logic           full;
  logic [DL2:0]   level;
  logic           ovf;
  logic           busy;
  logic           tx_vld;
  logic [DW-1:0]  tx_data;

  uart_tx_feeder #(
    .DATA_W(DW), .DEPTH_LOG2(DL2), .BAUD_DIV(BDIV), .FRAME_BITS(FBITS), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .level(level), .ovf(ovf), .busy(busy),
    .tx_vld(tx_vld), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  ent_t          q[$];      // model FIFO contents with arrival edge
  ent_t          exp_q[$];  // expected issues (byte, edge)
  int            cyc = 0;
  int            last_issue = 0;
  bit            have_issue = 0;
  bit            ovf_m = 0;
  logic [DW-1:0] last_data = '0;
  int            txm_cnt = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Reference model: a byte is issued at the first edge that is at least two edges after it
  // arrived and at least PACE edges after the previous issue.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        exp_q.delete();
        have_issue = 0;
        ovf_m      = 0;
        last_data  = '0;
        txm_cnt    = 0;
      end else begin
        bit pre_full;
        pre_full = (q.size() == DEPTH);
        ovf_m    = wr_en && pre_full;
        if (q.size() > 0 && cyc >= q[0].t + 2 && (!have_issue || cyc >= last_issue + PACE)) begin
          exp_q.push_back('{d: q[0].d, t: cyc});
          last_data  = q[0].d;
          last_issue = cyc;
          have_issue = 1;
          void'(q.pop_front());
        end
        if (wr_en && !pre_full) q.push_back('{d: wr_data, t: cyc});
      end
    end
  end

  // Monitor: per-cycle status checks plus scoreboard pops on every tx_vld.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit busy_m;
        busy_m = (q.size() != 0) || (have_issue && cyc <= last_issue + PACE - 3);
        chk("level", int'(level), q.size());
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("ovf", int'(ovf), int'(ovf_m));
        chk("busy", int'(busy), int'(busy_m));
        chk("tx_data_hold", int'(tx_data), int'(last_data));
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
          chk("missed_issue", cyc, exp_q[0].t);
          void'(exp_q.pop_front());
        end
        if (tx_vld) begin
          chk("tx_vld_mid_frame", int'(txm_cnt > 0), 0);
          txm_cnt = FRAME;
          if (exp_q.size() == 0) begin
            chk("unexpected_tx_vld", 1, 0);
          end else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("issue_data", int'(tx_data), int'(e.d));
            chk("issue_cycle", cyc, e.t);
          end
        end else if (txm_cnt > 0) begin
          txm_cnt--;
        end
      end
    end
  end

  task automatic put(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_full"},    int'(full), 0);
    chk({name, "_level"},   int'(level), 0);
    chk({name, "_ovf"},     int'(ovf), 0);
    chk({name, "_busy"},    int'(busy), 0);
    chk({name, "_tx_vld"},  int'(tx_vld), 0);
    chk({name, "_tx_data"}, int'(tx_data), 0);
  endtask

  initial begin
    int k;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    idle(3);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Single byte from reset.
    put(8'h55);
    idle(60);

    // Three-byte burst.
    put(8'hA1); put(8'hA2); put(8'hA3);
    idle(3 * PACE + 10);

    // Overfill a depth-4 FIFO, then collide a write with a pop while full.
    for (int i = 0; i < 6; i++) put(8'h10 + 8'(i));
    k = 0;
    while (cyc != last_issue + PACE - 1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_pop_edge", int'(k < 200), 1);
    chk("full_before_collision", int'(full), 1);
    put(8'h77);
    put(8'h78);
    idle(6 * PACE);

    // Reset while waiting with bytes still queued.
    put(8'h31); put(8'h32); put(8'h33);
    k = 0;
    while (!tx_vld && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_first_issue", int'(k < 200), 1);
    idle(10);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    idle(2);
    rst_n = 1'b1;
    idle(100);
    put(8'h44);
    idle(PACE + 10);

    // Edge-value bytes through the transmitter model.
    put(8'h00); put(8'hFF); put(8'h3C);
    idle(4 * PACE);

    // Random traffic: sparse, then heavy enough to overflow.
    for (int ph = 0; ph < 4; ph++) begin
      int p;
      p = (ph % 2 == 0) ? 3 : 50;
      for (int c = 0; c < 700; c++) begin
        wr_en   = ($urandom_range(0, 99) < p);
        wr_data = 8'($urandom);
        @(negedge clk);
      end
      wr_en = 1'b0;
    end
    idle((DEPTH + 2) * PACE);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("model_fifo_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
